// File: rtl/button_event_arbiter.sv
// Round-robin arbiter turning per-button press/release pulses into an ordered event FIFO.
// Optional long-press detection is enabled by defining BUTTON_EVENT_LONGPRESS_EN.
module button_event_arbiter #(
  parameter int IDW   = 2,
  parameter int DEPTH = 4,
  parameter int HOLD  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [(1<<IDW)-1:0]   rising,
  input  logic [(1<<IDW)-1:0]   falling,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IDW-1:0]        evt_id,
  output logic                  evt_edge,
  output logic                  evt_long,
  output logic [(1<<IDW)-1:0]   held,
  output logic                  overflow
);

  localparam int N  = 1 << IDW;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = IDW + 2;
`ifdef BUTTON_EVENT_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic [N-1:0]   press_p, long_p, rel_p, held_q;
  logic [N-1:0]   press_clr, long_clr, rel_clr, long_set;
  logic [N-1:0]   any_p;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  head, push_entry;
  logic [IDW-1:0] rr_ptr, win, cand;
  logic           found, full, empty, pop, push, ovf_hit;

  assign any_p = press_p | long_p | rel_p;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && evt_ready;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = rr_ptr + IDW'(k);
      if (!found && any_p[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign push = found && (!full || pop);

  always_comb begin
    press_clr  = '0;
    long_clr   = '0;
    rel_clr    = '0;
    push_entry = '0;
    if (push) begin
      if (press_p[win]) begin
        press_clr[win] = 1'b1;
        push_entry     = {win, 1'b1, 1'b0};
      end else if (long_p[win]) begin
        long_clr[win]  = 1'b1;
        push_entry     = {win, 1'b1, 1'b1};
      end else begin
        rel_clr[win]   = 1'b1;
        push_entry     = {win, 1'b0, 1'b0};
      end
    end
  end

`ifdef BUTTON_EVENT_LONGPRESS_EN
  localparam int CW = $clog2(HOLD + 1);
  logic [CW-1:0] hold_cnt [N];

  // Counter saturates at HOLD so the HOLD-1 match fires once per press.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (reset || rising[i] || !held_q[i])
        hold_cnt[i] <= '0;
      else if (hold_cnt[i] != CW'(HOLD))
        hold_cnt[i] <= hold_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    long_set = '0;
    for (int unsigned i = 0; i < N; i++)
      long_set[i] = held_q[i] && !rising[i] && (hold_cnt[i] == CW'(HOLD - 1));
  end
`else
  assign long_set = '0;
`endif

  // A pulse only counts as dropped if its flag stays set through this edge.
  assign ovf_hit = |((rising & press_p & ~press_clr) |
                     (falling & rel_p & ~rel_clr) |
                     (long_set & long_p & ~long_clr));

  always_ff @(posedge clk) begin
    if (reset) begin
      press_p  <= '0;
      long_p   <= '0;
      rel_p    <= '0;
      held_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      press_p <= (press_p & ~press_clr) | rising;
      long_p  <= (long_p & ~long_clr) | long_set;
      rel_p   <= (rel_p & ~rel_clr) | falling;
      held_q  <= (held_q | rising) & ~falling;
      if (ovf_hit)
        overflow <= 1'b1;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + 1'b1;
        rr_ptr              <= win + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_valid = !empty;
  assign evt_id    = head[EW-1:2];
  assign evt_edge  = head[1];
  assign evt_long  = head[0] & LONG_EN;
  assign held      = held_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter (IDW=2, DEPTH=4, HOLD=16).
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rising, falling;
  logic       evt_valid, evt_ready, evt_edge, evt_long, overflow;
  logic [1:0] evt_id;
  logic [3:0] held;

  int total = 0;
  int bad   = 0;

  logic [1:0] rec_id   [8];
  logic       rec_edge [8];
  logic       rec_long [8];
  int         nrec;

  button_event_arbiter #(.IDW(2), .DEPTH(4), .HOLD(16)) dut (
    .clk(clk), .reset(reset), .rising(rising), .falling(falling),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_edge(evt_edge), .evt_long(evt_long), .held(held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [1:0] id, input logic edg);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_id"},    32'(evt_id),    32'(id));
    chk({tag, "_edge"},  32'(evt_edge),  32'(edg));
    chk({tag, "_long"},  32'(evt_long),  32'd0);
  endtask

  task automatic record();
    if (evt_valid && nrec < 8) begin
      rec_id[nrec]   = evt_id;
      rec_edge[nrec] = evt_edge;
      rec_long[nrec] = evt_long;
      nrec++;
    end
  endtask

  initial begin
    rising = '0; falling = '0; evt_ready = 1'b0; reset = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_held",  32'(held),      32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);

    // Single press on button 2: valid two edges after pulse, popped next
    evt_ready = 1'b1;
    rising = 4'b0100; tick(); rising = '0;
    chk("t1_early_valid", 32'(evt_valid), 32'd0);
    chk("t1_held", 32'(held), 32'b0100);
    tick();
    chk_head("t1_head", 2'd2, 1'b1);
    tick();
    chk("t1_popped", 32'(evt_valid), 32'd0);

    // All four pressed: round-robin 0..3, then 0,1 after wrap
    do_reset();
    evt_ready = 1'b1;
    rising = 4'b1111; tick(); rising = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_head($sformatf("t2_ev%0d", k), 2'(k), 1'b1);
    end
    tick();
    chk("t2_empty", 32'(evt_valid), 32'd0);
    chk("t2_held", 32'(held), 32'b1111);
    rising = 4'b0011; tick(); rising = '0;
    tick(); chk_head("t2_wrap0", 2'd0, 1'b1);
    tick(); chk_head("t2_wrap1", 2'd1, 1'b1);
    tick(); chk("t2_empty2", 32'(evt_valid), 32'd0);

    // Backpressure: 6 events, 4 queued, 2 pending, then drained in order
    do_reset();
    evt_ready = 1'b0;
    rising = 4'b0111; falling = 4'b0111; tick(); rising = '0; falling = '0;
    for (int k = 0; k < 6; k++) tick();
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_held", 32'(held), 32'd0);
    evt_ready = 1'b1;
    chk_head("t3_d0", 2'd0, 1'b1); tick();
    chk_head("t3_d1", 2'd1, 1'b1); tick();
    chk_head("t3_d2", 2'd2, 1'b1); tick();
    chk_head("t3_d3", 2'd0, 1'b0); tick();
    chk_head("t3_d4", 2'd1, 1'b0); tick();
    chk_head("t3_d5", 2'd2, 1'b0); tick();
    chk("t3_empty", 32'(evt_valid), 32'd0);
    chk("t3_ovf_end", 32'(overflow), 32'd0);

    // Overflow: second press on button 1 while first is held back by a full FIFO
    do_reset();
    evt_ready = 1'b0;
    rising = 4'b1111; tick(); rising = '0;
    for (int k = 0; k < 5; k++) tick();
    rising = 4'b0010; tick(); rising = '0; tick();
    chk("t4_ovf_first", 32'(overflow), 32'd0);
    rising = 4'b0010; tick(); rising = '0;
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("t4_drained", 32'(evt_valid), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);

    // Hold button 3 for 20 cycles then release
    evt_ready = 1'b1;
    nrec = 0;
    rising = 4'b1000; tick(); rising = '0; record();
    for (int k = 0; k < 20; k++) begin tick(); record(); end
    falling = 4'b1000; tick(); falling = '0; record();
    for (int k = 0; k < 4; k++) begin tick(); record(); end
`ifdef BUTTON_EVENT_LONGPRESS_EN
    chk("t5_count", 32'(nrec), 32'd3);
    chk("t5_e0", {rec_id[0], rec_edge[0], rec_long[0]}, {2'd3, 1'b1, 1'b0});
    chk("t5_e1", {rec_id[1], rec_edge[1], rec_long[1]}, {2'd3, 1'b1, 1'b1});
    chk("t5_e2", {rec_id[2], rec_edge[2], rec_long[2]}, {2'd3, 1'b0, 1'b0});
`else
    chk("t5_count", 32'(nrec), 32'd2);
    chk("t5_e0", {rec_id[0], rec_edge[0], rec_long[0]}, {2'd3, 1'b1, 1'b0});
    chk("t5_e1", {rec_id[1], rec_edge[1], rec_long[1]}, {2'd3, 1'b0, 1'b0});
`endif
    chk("t5_held", 32'(held), 32'd0);

    // Reset mid-operation with 3 queued and 2 pending
    do_reset();
    evt_ready = 1'b0;
    rising = 4'b0111; falling = 4'b0011; tick(); rising = '0; falling = '0;
    tick(); tick(); tick();
    chk("t6_pre_valid", 32'(evt_valid), 32'd1);
    chk("t6_pre_held", 32'(held), 32'b0100);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_valid", 32'(evt_valid), 32'd0);
    chk("t6_held", 32'(held), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    nrec = 0;
    for (int k = 0; k < 6; k++) begin tick(); record(); end
    chk("t6_no_stale", 32'(nrec), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
